hhmm_seg_scanner: RTL and testbench
===================================

// Module: hhmm_seg_scanner
// PURPOSE
//  Display-side consumer of the clock's BCD digits (hour QH/QL, minute MH/ML).
//  Drives the board's 4-digit common-anode 7-segment display as HH.MM by time-multiplexing the anodes.
//  Snapshots all digits once per scan frame so the display never tears.
//  Inserts a dead gap between digits against ghosting, blanks the leading hour zero, and shows '-' for invalid BCD.
// PARAMETERS
//  SCAN_DIV  50000  cycles each digit is lit (>=2)
//  GAP_CYC   16     cycles all anodes off before each digit (>=1)
//  LZB       1      1 = blank hour-tens digit when it is 0
// PORTS
//  CLK    in   1  system clock, single clock domain
//  RST_N  in   1  synchronous reset, active-low
//  QH     in   2  hour tens BCD (0..2 valid)
//  QL     in   4  hour units BCD (0..9 valid)
//  MH     in   3  minute tens BCD (0..5 valid)
//  ML     in   4  minute units BCD (0..9 valid)
//  COLON  in   1  1 = light separator DP on digit 2
//  BLANK  in   1  1 = all anodes off; scanning continues
//  AN     out  4  anode enables, active-low: AN[0]=ML, AN[1]=MH, AN[2]=QL, AN[3]=QH
//  SEG    out  7  {g,f,e,d,c,b,a}, active-low
//  DP     out  1  decimal point, active-low
// BEHAVIOUR
//  Reset: RST_N=0 at a rising edge -> state=GAP, idx=0, gcnt=0, ocnt=0, snapshots=0, AN=4'b1111, SEG=7'h7F, DP=1.
//   Applies from any state; mid-slot reset restarts the frame at idx 0.
//  FSM: two states, GAP and ON, plus a 2-bit digit index idx.
//   GAP: gcnt counts 0..GAP_CYC-1. At gcnt==GAP_CYC-1 -> ON, ocnt=0. GAP lasts exactly GAP_CYC cycles.
//   ON: ocnt counts 0..SCAN_DIV-1. At the end -> GAP, gcnt=0, idx=idx+1 (3 wraps to 0).
//   Frame = 4*(GAP_CYC+SCAN_DIV) cycles.
//  Snapshot: QH, QL, MH, ML and COLON are registered in the cycle where state==GAP, idx==0 and gcnt==0.
//   This includes the first cycle after reset release.
//   Input changes at any other time are not displayed until the next frame.
//  Outputs are registered and computed from the next state, so AN, SEG and DP change on the same edge as the state.
//  During GAP: AN=1111, SEG=7F, DP=1.
//  During ON: AN=~(4'b0001<<idx), SEG=decode(snapshot digit[idx]), DP=0 only when idx==2 and snapshot COLON==1.
//  Decode (gfedcba, active-low):
//   0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//   5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//  Invalid digit shows dash 0111111. Invalid means ML/QL>9, MH>5 or QH==3.
//  Leading zero: LZB=1 and snapshot QH==0 -> the idx-3 ON slot has AN=1111 and SEG=7F.
//  BLANK: sampled live. While BLANK=1 at an edge, that edge loads AN=1111, SEG=7F, DP=1.
//   FSM, counters and snapshots keep running.
//  Width rules: counters sized $clog2 of their parameter. idx is 2 bits and wraps naturally.
// TESTING
//  (All with SCAN_DIV=4, GAP_CYC=2.)
//  Reset: hold RST_N=0 for 3 cycles -> AN=1111, SEG=7F, DP=1.
//   After release: AN=1110 from the 2nd edge, held 4 cycles, then 2 cycles of 1111.
//  23:59, COLON=1 -> ON-slot sequence:
//   AN1110/SEG0010000, AN1101/SEG0010010, AN1011/SEG0110000 with DP=0, AN0111/SEG0100100.
//   Frame repeats every 24 cycles.
//  07:05: LZB=1 -> idx-3 slot has AN=1111, SEG=7F. LZB=0 -> AN=0111, SEG=1000000.
//  Inputs 12:34, change to 18:00 during the idx-1 slot -> idx 2/3 still show 2/1; the next frame shows 18:00.
//  ML=4'hC, QH=3 -> those slots show SEG=0111111. Pulse BLANK=1 for 3 cycles mid-slot -> AN=1111 for 3 cycles, slot timing unchanged.
//  Drop RST_N during the idx-2 ON slot -> reset outputs on the next edge; after release, the frame restarts at idx 0 with a fresh snapshot.

Source files
------------

// File: rtl/hhmm_seg_scanner_if.sv
// Display bus between the time source (master) and the 7-segment scanner (slave).
// The master supplies BCD time digits and display controls.
// The slave returns the anode, segment and decimal-point drives.
interface hhmm_seg_scanner_if;
    logic [1:0] qh;
    logic [3:0] ql;
    logic [2:0] mh;
    logic [3:0] ml;
    logic       colon;
    logic       blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output qh, ql, mh, ml, colon, blank,
        input  an, seg, dp
    );

    modport slave (
        input  qh, ql, mh, ml, colon, blank,
        output an, seg, dp
    );
endinterface

// File: rtl/hhmm_seg_scanner.sv
// Time-multiplexed HH.MM driver for a 4-digit common-anode 7-segment display.
// Digits are snapshotted once per frame so a frame never mixes old and new time.
// Each digit slot starts with a dark gap against ghosting.
// The hour-tens zero can be blanked, and invalid BCD is shown as a dash.
module hhmm_seg_scanner #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned GAP_CYC  = 16,
    parameter bit          LZB      = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    hhmm_seg_scanner_if.slave  bus
);

    localparam int unsigned OW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned GW = (GAP_CYC  > 1) ? $clog2(GAP_CYC)  : 1;
    localparam logic [OW-1:0] O_LAST = OW'(SCAN_DIV - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [3:0] AN_OFF   = 4'hF;

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [GW-1:0] gcnt, gcnt_nxt;
    logic [OW-1:0] ocnt, ocnt_nxt;

    logic [1:0]    snap_qh, snap_qh_nxt;
    logic [3:0]    snap_ql, snap_ql_nxt;
    logic [2:0]    snap_mh, snap_mh_nxt;
    logic [3:0]    snap_ml, snap_ml_nxt;
    logic          snap_colon, snap_colon_nxt;

    logic [3:0]    an_q, an_nxt;
    logic [6:0]    seg_q, seg_nxt;
    logic          dp_q, dp_nxt;

    logic [3:0]    digit;
    logic          digit_ok;

    // BCD digit to active-low gfedcba pattern; non-decimal codes render as a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_DASH;
        endcase
        return p;
    endfunction

    // State, counters, snapshot and registered display drives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_GAP;
            idx        <= 2'd0;
            gcnt       <= '0;
            ocnt       <= '0;
            snap_qh    <= 2'd0;
            snap_ql    <= 4'd0;
            snap_mh    <= 3'd0;
            snap_ml    <= 4'd0;
            snap_colon <= 1'b0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_OFF;
            dp_q       <= 1'b1;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            gcnt       <= gcnt_nxt;
            ocnt       <= ocnt_nxt;
            snap_qh    <= snap_qh_nxt;
            snap_ql    <= snap_ql_nxt;
            snap_mh    <= snap_mh_nxt;
            snap_ml    <= snap_ml_nxt;
            snap_colon <= snap_colon_nxt;
            an_q       <= an_nxt;
            seg_q      <= seg_nxt;
            dp_q       <= dp_nxt;
        end
    end

    // Slot sequencing, frame-start snapshot and drive values for the next state.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        gcnt_nxt       = gcnt;
        ocnt_nxt       = ocnt;
        snap_qh_nxt    = snap_qh;
        snap_ql_nxt    = snap_ql;
        snap_mh_nxt    = snap_mh;
        snap_ml_nxt    = snap_ml;
        snap_colon_nxt = snap_colon;
        an_nxt         = AN_OFF;
        seg_nxt        = SEG_OFF;
        dp_nxt         = 1'b1;
        digit          = 4'd0;
        digit_ok       = 1'b1;

        case (state)
            ST_GAP: begin
                // First gap cycle of digit 0 is the frame start: latch the time.
                if (idx == 2'd0 && gcnt == '0) begin
                    snap_qh_nxt    = bus.qh;
                    snap_ql_nxt    = bus.ql;
                    snap_mh_nxt    = bus.mh;
                    snap_ml_nxt    = bus.ml;
                    snap_colon_nxt = bus.colon;
                end
                if (gcnt == G_LAST) begin
                    state_nxt = ST_ON;
                    ocnt_nxt  = '0;
                end else begin
                    gcnt_nxt = gcnt + GW'(1);
                end
            end
            ST_ON: begin
                if (ocnt == O_LAST) begin
                    state_nxt = ST_GAP;
                    gcnt_nxt  = '0;
                    idx_nxt   = idx + 2'd1;
                end else begin
                    ocnt_nxt = ocnt + OW'(1);
                end
            end
            default: begin
                state_nxt = ST_GAP;
                gcnt_nxt  = '0;
                idx_nxt   = 2'd0;
            end
        endcase

        // Digit shown in the upcoming slot, using the snapshot as it will be after this edge.
        case (idx_nxt)
            2'd0: begin
                digit    = snap_ml_nxt;
                digit_ok = (snap_ml_nxt <= 4'd9);
            end
            2'd1: begin
                digit    = 4'(snap_mh_nxt);
                digit_ok = (snap_mh_nxt <= 3'd5);
            end
            2'd2: begin
                digit    = snap_ql_nxt;
                digit_ok = (snap_ql_nxt <= 4'd9);
            end
            default: begin
                digit    = 4'(snap_qh_nxt);
                digit_ok = (snap_qh_nxt != 2'd3);
            end
        endcase

        // Light the selected anode only while ON and not blanked.
        if (state_nxt == ST_ON && !bus.blank) begin
            an_nxt  = ~(4'b0001 << idx_nxt);
            seg_nxt = digit_ok ? decode(digit) : SEG_DASH;
            dp_nxt  = ~(idx_nxt == 2'd2 && snap_colon_nxt);
            if (LZB && idx_nxt == 2'd3 && snap_qh_nxt == 2'd0) begin
                an_nxt  = AN_OFF;
                seg_nxt = SEG_OFF;
            end
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_hhmm_seg_scanner.sv
// Bench for hhmm_seg_scanner with SCAN_DIV=4, GAP_CYC=2: one instance with leading-zero
// blanking, one without, both fed the same inputs and checked every cycle against a
// frame-position model plus fixed expected patterns at key cycles.
module tb_hhmm_seg_scanner;

    localparam int S     = 4;
    localparam int G     = 2;
    localparam int SLOT  = S + G;
    localparam int FRAME = 4 * SLOT;
    localparam logic [6:0] PAT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    hhmm_seg_scanner_if bus0();
    hhmm_seg_scanner_if bus1();

    assign bus1.qh    = bus0.qh;
    assign bus1.ql    = bus0.ql;
    assign bus1.mh    = bus0.mh;
    assign bus1.ml    = bus0.ml;
    assign bus1.colon = bus0.colon;
    assign bus1.blank = bus0.blank;

    hhmm_seg_scanner #(.SCAN_DIV(S), .GAP_CYC(G), .LZB(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    hhmm_seg_scanner #(.SCAN_DIV(S), .GAP_CYC(G), .LZB(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    // Reference: position inside the frame decides which digit is lit.
    int         pos;
    int         m_qh, m_ql, m_mh, m_ml;
    bit         m_colon;
    logic [3:0] e0_an, e1_an;
    logic [6:0] e0_seg, e1_seg;
    logic       e_dp;

    function automatic logic [6:0] seg_of(input int v, input int maxv);
        if (v > maxv) return 7'b0111111;
        return PAT[v];
    endfunction

    always @(posedge clk) begin
        int slot;
        int v;
        int maxv;
        if (!rst_n) begin
            pos = 0; m_qh = 0; m_ql = 0; m_mh = 0; m_ml = 0; m_colon = 0;
            e0_an = 4'hF; e1_an = 4'hF; e0_seg = 7'h7F; e1_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            if (pos == 0) begin
                m_qh = int'(bus0.qh); m_ql = int'(bus0.ql);
                m_mh = int'(bus0.mh); m_ml = int'(bus0.ml);
                m_colon = bus0.colon;
            end
            pos  = (pos + 1) % FRAME;
            slot = pos / SLOT;
            e0_an = 4'hF; e1_an = 4'hF; e0_seg = 7'h7F; e1_seg = 7'h7F; e_dp = 1'b1;
            if ((pos % SLOT) >= G && !bus0.blank) begin
                case (slot)
                    0: begin v = m_ml; maxv = 9; end
                    1: begin v = m_mh; maxv = 5; end
                    2: begin v = m_ql; maxv = 9; end
                    default: begin v = m_qh; maxv = 2; end
                endcase
                e1_an  = 4'hF ^ (4'd1 << slot);
                e1_seg = seg_of(v, maxv);
                e_dp   = !(slot == 2 && m_colon);
                e0_an  = e1_an;
                e0_seg = e1_seg;
                if (slot == 3 && m_qh == 0) begin
                    e0_an = 4'hF; e0_seg = 7'h7F;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_time(input int qh, input int ql, input int mh, input int ml, input bit col);
        bus0.qh = 2'(qh); bus0.ql = 4'(ql); bus0.mh = 3'(mh); bus0.ml = 4'(ml); bus0.colon = col;
    endtask

    task automatic restart();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] an_tab [1:8];
        an_tab = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};
        rst_n = 1'b0;
        set_time(1, 2, 3, 4, 1'b0);
        bus0.blank = 1'b0;
        for (int k = 0; k < 3; k++) step();
        total++;
        if ({bus0.an, bus0.seg, bus0.dp} !== {4'hF, 7'h7F, 1'b1}) begin
            bad++;
            $display("FAIL reset: an=%b seg=%b dp=%b want 1111 1111111 1", bus0.an, bus0.seg, bus0.dp);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            total++;
            if (bus0.an !== an_tab[k]) begin
                bad++;
                $display("FAIL reset_release edge=%0d: an=%b want %b", k, bus0.an, an_tab[k]);
            end
        end
    endtask

    task automatic test_2359();
        set_time(2, 3, 5, 9, 1'b1);
        restart();
        for (int k = 1; k <= 2 * FRAME + 2; k++) begin
            step();
            total++;
            if ({bus0.an, bus0.seg, bus0.dp} !== {e0_an, e0_seg, e_dp}) begin
                bad++;
                $display("FAIL t2359 edge=%0d: got %b/%b/%b want %b/%b/%b", k,
                         bus0.an, bus0.seg, bus0.dp, e0_an, e0_seg, e_dp);
            end
            if (k == 2 || k == 8 || k == 14 || k == 20 || k == 26) begin
                logic [11:0] want;
                case (k)
                    2, 26:   want = {4'b1110, 7'b0010000, 1'b1};
                    8:       want = {4'b1101, 7'b0010010, 1'b1};
                    14:      want = {4'b1011, 7'b0110000, 1'b0};
                    default: want = {4'b0111, 7'b0100100, 1'b1};
                endcase
                total++;
                if ({bus0.an, bus0.seg, bus0.dp} !== want) begin
                    bad++;
                    $display("FAIL t2359_fixed edge=%0d: got %b want %b", k,
                             {bus0.an, bus0.seg, bus0.dp}, want);
                end
            end
        end
    endtask

    task automatic test_lzb();
        set_time(0, 7, 0, 5, 1'b0);
        restart();
        for (int k = 1; k <= FRAME; k++) begin
            step();
            total++;
            if ({bus0.an, bus0.seg, bus1.an, bus1.seg, bus1.dp} !== {e0_an, e0_seg, e1_an, e1_seg, e_dp}) begin
                bad++;
                $display("FAIL lzb edge=%0d: got %b/%b %b/%b want %b/%b %b/%b", k,
                         bus0.an, bus0.seg, bus1.an, bus1.seg, e0_an, e0_seg, e1_an, e1_seg);
            end
            if (k == 20) begin
                total++;
                if ({bus0.an, bus0.seg, bus1.an, bus1.seg} !== {4'hF, 7'h7F, 4'b0111, 7'b1000000}) begin
                    bad++;
                    $display("FAIL lzb_fixed: got %b/%b %b/%b want 1111/1111111 0111/1000000",
                             bus0.an, bus0.seg, bus1.an, bus1.seg);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        set_time(1, 2, 3, 4, 1'b1);
        restart();
        for (int k = 1; k <= 2 * FRAME; k++) begin
            step();
            if (k == 9) set_time(1, 8, 0, 0, 1'b1);
            total++;
            if ({bus0.an, bus0.seg, bus0.dp} !== {e0_an, e0_seg, e_dp}) begin
                bad++;
                $display("FAIL snapshot edge=%0d: got %b/%b/%b want %b/%b/%b", k,
                         bus0.an, bus0.seg, bus0.dp, e0_an, e0_seg, e_dp);
            end
            if (k == 14 || k == 20 || k == 26 || k == 38) begin
                logic [6:0] want;
                case (k)
                    14:      want = 7'b0100100;
                    20:      want = 7'b1111001;
                    26:      want = 7'b1000000;
                    default: want = 7'b0000000;
                endcase
                total++;
                if (bus0.seg !== want) begin
                    bad++;
                    $display("FAIL snapshot_fixed edge=%0d: seg=%b want %b", k, bus0.seg, want);
                end
            end
        end
    endtask

    task automatic test_invalid_blank();
        set_time(3, 1, 2, 12, 1'b0);
        restart();
        for (int k = 1; k <= FRAME + 2; k++) begin
            step();
            bus0.blank = (k >= 8 && k <= 10);
            total++;
            if ({bus0.an, bus0.seg, bus0.dp} !== {e0_an, e0_seg, e_dp}) begin
                bad++;
                $display("FAIL inv_blank edge=%0d: got %b/%b/%b want %b/%b/%b", k,
                         bus0.an, bus0.seg, bus0.dp, e0_an, e0_seg, e_dp);
            end
            if (k == 2 || k == 20 || (k >= 9 && k <= 11) || k == 14) begin
                logic [10:0] want;
                if (k == 2)       want = {4'b1110, 7'b0111111};
                else if (k == 20) want = {4'b0111, 7'b0111111};
                else if (k == 14) want = {4'b1011, 7'b1111001};
                else              want = {4'b1111, 7'h7F};
                total++;
                if ({bus0.an, bus0.seg} !== want) begin
                    bad++;
                    $display("FAIL inv_blank_fixed edge=%0d: got %b want %b", k, {bus0.an, bus0.seg}, want);
                end
            end
        end
        bus0.blank = 1'b0;
    endtask

    task automatic test_reset_midslot();
        set_time(2, 1, 4, 7, 1'b1);
        restart();
        for (int k = 1; k <= 15; k++) step();
        set_time(1, 9, 5, 8, 1'b0);
        rst_n = 1'b0;
        step();
        total++;
        if ({bus0.an, bus0.seg, bus0.dp} !== {4'hF, 7'h7F, 1'b1}) begin
            bad++;
            $display("FAIL midslot_reset: got %b/%b/%b want 1111/1111111/1", bus0.an, bus0.seg, bus0.dp);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= FRAME; k++) begin
            step();
            total++;
            if ({bus0.an, bus0.seg, bus0.dp} !== {e0_an, e0_seg, e_dp}) begin
                bad++;
                $display("FAIL midslot_restart edge=%0d: got %b/%b/%b want %b/%b/%b", k,
                         bus0.an, bus0.seg, bus0.dp, e0_an, e0_seg, e_dp);
            end
            if (k == 2) begin
                total++;
                if ({bus0.an, bus0.seg} !== {4'b1110, 7'b0000000}) begin
                    bad++;
                    $display("FAIL midslot_fixed: got %b/%b want 1110/0000000", bus0.an, bus0.seg);
                end
            end
        end
    endtask

    task automatic test_random();
        restart();
        for (int k = 0; k < 2000; k++) begin
            step();
            total++;
            if ({bus0.an, bus0.seg, bus0.dp, bus1.an, bus1.seg} !== {e0_an, e0_seg, e_dp, e1_an, e1_seg}) begin
                bad++;
                $display("FAIL random cyc=%0d: got %b/%b/%b %b/%b want %b/%b/%b %b/%b", k,
                         bus0.an, bus0.seg, bus0.dp, bus1.an, bus1.seg,
                         e0_an, e0_seg, e_dp, e1_an, e1_seg);
            end
            if ($urandom_range(7) == 0)
                set_time(int'($urandom_range(3)), int'($urandom_range(15)),
                         int'($urandom_range(7)), int'($urandom_range(15)), 1'($urandom_range(1)));
            bus0.blank = ($urandom_range(9) == 0);
            rst_n = ($urandom_range(299) != 0);
        end
        rst_n = 1'b1;
        bus0.blank = 1'b0;
    endtask

    initial begin
        bus0.blank = 1'b0;
        test_reset();
        test_2359();
        test_lzb();
        test_snapshot();
        test_invalid_blank();
        test_reset_midslot();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
